// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for seq_chunk_adder: FSM state encoding and chunk-count helpers.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int unsigned nchunk_of(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-chunk build still needs a 1-bit counter.
  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice; msb_cin is the carry into the top bit.
module rca_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout    = c[CHUNK];
  assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder reusing one CHUNK-bit ripple stage, LSB chunk first.
// Optional subtract mode and signed overflow output enabled by SEQ_ADD_SUB_EN.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_ADD_SUB_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int unsigned IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((CHUNK == 0) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [CHUNK-1:0] ch_a;
  logic [CHUNK-1:0] ch_b;
  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;
  logic             sub_sel;

`ifdef SEQ_ADD_SUB_EN
  logic ch_msb_cin;
  logic msb_cin_q;
  assign sub_sel = sub;
`else
  logic ch_msb_cin_unused;
  assign sub_sel = 1'b0;
`endif

  assign ch_a = a_reg[idx*CHUNK +: CHUNK];
  assign ch_b = b_reg[idx*CHUNK +: CHUNK];

  rca_chunk #(
    .CHUNK(CHUNK)
  ) u_rca (
    .a      (ch_a),
    .b      (ch_b),
    .cin    (carry),
    .sum    (ch_sum),
    .cout   (ch_cout),
`ifdef SEQ_ADD_SUB_EN
    .msb_cin(ch_msb_cin)
`else
    .msb_cin(ch_msb_cin_unused)
`endif
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
      msb_cin_q <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      // done is registered as the FSM leaves DONE, so it lines up with the updated sum.
      done  <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= sub_sel ? ~B : B;
            carry <= sub_sel | cin;
            idx   <= '0;
          end
        end
        S_RUN: begin
          acc[idx*CHUNK +: CHUNK] <= ch_sum;
          carry <= ch_cout;
          idx   <= idx + 1'b1;
`ifdef SEQ_ADD_SUB_EN
          msb_cin_q <= ch_msb_cin;
`endif
        end
        S_DONE: begin
          sum  <= acc;
          cout <= carry;
`ifdef SEQ_ADD_SUB_EN
          ovf  <= carry ^ msb_cin_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
